// File: rtl/edit_field_sequencer_pkg.sv
// Shared key codes, state encoding and field encoding for the date-edit sequencer.
// Field step helpers live here so every user wraps the field the same way.
package edit_field_sequencer_pkg;

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_BREAK = 2'd2,
        ST_EXT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE  = 2'd0,
        FIELD_DAY   = 2'd1,
        FIELD_MONTH = 2'd2,
        FIELD_YEAR  = 2'd3
    } field_t;

    // Prefix tracking inside the make-code filter.
    typedef enum logic [1:0] {
        PFX_NONE  = 2'd0,
        PFX_EXT   = 2'd1,
        PFX_BREAK = 2'd2
    } pfx_t;

    function automatic field_t field_next(input field_t f);
        case (f)
            FIELD_DAY:   return FIELD_MONTH;
            FIELD_MONTH: return FIELD_YEAR;
            default:     return FIELD_DAY;
        endcase
    endfunction

    function automatic field_t field_prev(input field_t f);
        case (f)
            FIELD_DAY:   return FIELD_YEAR;
            FIELD_MONTH: return FIELD_DAY;
            FIELD_YEAR:  return FIELD_MONTH;
            default:     return FIELD_YEAR;
        endcase
    endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Strips PS/2 set-2 prefixes: E0 is swallowed, F0 swallows itself and the next byte.
// make_valid is combinational from got_data so the sequencer can register its response in one cycle.
module ps2_make_filter
    import edit_field_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       got_data,
    output logic       make_valid,
    output logic [7:0] make_code
);

    pfx_t pfx;

    always_comb begin
        make_valid = got_data
                     && (pfx != PFX_BREAK)
                     && (scan_code != KEY_BREAK)
                     && (scan_code != KEY_EXT);
        make_code  = scan_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pfx <= PFX_NONE;
        end else if (got_data) begin
            if (pfx == PFX_BREAK)
                pfx <= PFX_NONE;
            else if (scan_code == KEY_BREAK)
                pfx <= PFX_BREAK;
            else if (scan_code == KEY_EXT)
                pfx <= PFX_EXT;
            else
                pfx <= PFX_NONE;
        end
    end

endmodule

// File: rtl/edit_field_sequencer.sv
// Keyboard-driven date-field editor: Enter starts/commits, arrows step or select, Esc or idle timeout aborts.
// Every output is a register updated on the edge that samples got_data.
module edit_field_sequencer
    import edit_field_sequencer_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000,
    parameter int unsigned TW          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       got_data,
    output logic [1:0] field_sel,
    output logic       editing,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit_pulse,
    output logic       abort_pulse
);

    // Abort is registered on the edge where the idle count reaches TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TMO_ARM = TW'(TIMEOUT_CYC - 32'd2);
    localparam logic [TW-1:0] TMO_SAT = {TW{1'b1}};

    logic          make_valid;
    logic [7:0]    make_code;
    state_t        state;
    field_t        field;
    logic [TW-1:0] timer;

    ps2_make_filter u_filter (
        .clk        (clk),
        .rst        (rst),
        .scan_code  (scan_code),
        .got_data   (got_data),
        .make_valid (make_valid),
        .make_code  (make_code)
    );

    assign field_sel = field;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            field        <= FIELD_NONE;
            editing      <= 1'b0;
            inc_pulse    <= 1'b0;
            dec_pulse    <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
            timer        <= '0;
        end else begin
            inc_pulse    <= 1'b0;
            dec_pulse    <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
            case (state)
                ST_EDIT: begin
                    if (got_data) begin
                        // Any byte, including prefixes and unmapped codes, counts as activity.
                        timer <= '0;
                        if (make_valid) begin
                            case (make_code)
                                KEY_UP:    inc_pulse <= 1'b1;
                                KEY_DOWN:  dec_pulse <= 1'b1;
                                KEY_RIGHT: field <= field_next(field);
                                KEY_LEFT:  field <= field_prev(field);
                                KEY_ENTER: begin
                                    commit_pulse <= 1'b1;
                                    state        <= ST_IDLE;
                                    field        <= FIELD_NONE;
                                    editing      <= 1'b0;
                                end
                                KEY_ESC: begin
                                    abort_pulse <= 1'b1;
                                    state       <= ST_IDLE;
                                    field       <= FIELD_NONE;
                                    editing     <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (timer == TMO_ARM) begin
                        abort_pulse <= 1'b1;
                        state       <= ST_IDLE;
                        field       <= FIELD_NONE;
                        editing     <= 1'b0;
                        timer       <= '0;
                    end else if (timer != TMO_SAT) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    if (make_valid && (make_code == KEY_ENTER)) begin
                        state   <= ST_EDIT;
                        field   <= FIELD_DAY;
                        editing <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edit_field_sequencer.sv
// Directed then randomized byte streams against a keystroke-level reference model.
module tb_edit_field_sequencer;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       got_data = 1'b0;
    logic [1:0] field_sel;
    logic       editing, inc_pulse, dec_pulse, commit_pulse, abort_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edit mode, selected field, pending-break flag, idle cycles since last byte.
    bit m_edit = 0;
    bit m_brk = 0;
    int m_field = 0;
    int m_idle = 0;
    bit e_inc, e_dec, e_com, e_abt;

    edit_field_sequencer #(.TIMEOUT_CYC(32'd16), .TW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_code    (scan_code),
        .got_data     (got_data),
        .field_sel    (field_sel),
        .editing      (editing),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .commit_pulse (commit_pulse),
        .abort_pulse  (abort_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_update(input bit g, input logic [7:0] c, input bit r);
        e_inc = 0; e_dec = 0; e_com = 0; e_abt = 0;
        if (r) begin
            m_edit = 0; m_brk = 0; m_field = 0; m_idle = 0;
        end else if (g) begin
            if (m_edit) m_idle = 0;
            if (m_brk) m_brk = 0;
            else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'hE0) m_brk = 0;
            else if (!m_edit) begin
                if (c == 8'h5A) begin m_edit = 1; m_field = 1; end
            end else begin
                case (c)
                    8'h75: e_inc = 1;
                    8'h72: e_dec = 1;
                    8'h74: m_field = m_field % 3 + 1;
                    8'h6B: m_field = (m_field + 1) % 3 + 1;
                    8'h5A: begin e_com = 1; m_edit = 0; m_field = 0; end
                    8'h76: begin e_abt = 1; m_edit = 0; m_field = 0; end
                    default: ;
                endcase
            end
        end else if (m_edit) begin
            m_idle++;
            if (m_idle == TMO - 1) begin
                e_abt = 1; m_edit = 0; m_field = 0; m_idle = 0;
            end
        end
    endtask

    task automatic tick(input bit g, input logic [7:0] c, input bit r, input string tag);
        logic [6:0] obs, exp;
        got_data = g; scan_code = c; rst = r;
        @(posedge clk);
        #1;
        got_data = 1'b0; rst = 1'b0;
        model_update(g, c, r);
        obs = {field_sel, editing, inc_pulse, dec_pulse, commit_pulse, abort_pulse};
        exp = {2'(m_field), m_edit, e_inc, e_dec, e_com, e_abt};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s vec%0d {field,edit,inc,dec,com,abt} observed=%b expected=%b",
                   tag, vectors, obs, exp);
        end
    endtask

    logic [7:0] code_tbl [10] = '{8'h5A, 8'h76, 8'h75, 8'h72, 8'h74,
                                  8'h6B, 8'hF0, 8'hE0, 8'h5A, 8'h00};

    initial begin
        tick(0, 8'h00, 1, "reset");
        tick(0, 8'h00, 1, "reset_hold");
        tick(0, 8'h00, 0, "reset_release");
        tick(1, 8'h75, 0, "idle_ignore");
        tick(1, 8'hF0, 0, "idle_break");
        tick(1, 8'h5A, 0, "idle_break_discard");
        tick(0, 8'h00, 0, "idle_after_break");
        tick(1, 8'h5A, 0, "enter_edit");
        tick(1, 8'h75, 0, "inc");
        tick(0, 8'h00, 0, "inc_done");
        tick(1, 8'hF0, 0, "break_f0");
        tick(1, 8'h75, 0, "break_discard");
        tick(0, 8'h00, 0, "break_quiet");
        tick(1, 8'h6B, 0, "left_wrap");
        tick(1, 8'h74, 0, "right_1");
        tick(1, 8'h74, 0, "right_2");
        tick(1, 8'h72, 0, "dec_month");
        tick(1, 8'h75, 0, "typematic_1");
        tick(1, 8'h75, 0, "typematic_2");
        tick(1, 8'h75, 0, "typematic_3");
        tick(1, 8'h33, 0, "unmapped");
        for (int i = 0; i < 16; i++) tick(0, 8'h00, 0, "timeout_run");
        tick(1, 8'h5A, 0, "reenter");
        for (int i = 0; i < 14; i++) tick(0, 8'h00, 0, "timeout_near");
        tick(1, 8'h11, 0, "key_at_expiry");
        for (int i = 0; i < 16; i++) tick(0, 8'h00, 0, "timeout_restart");
        tick(1, 8'h5A, 0, "enter_ext");
        tick(1, 8'hE0, 0, "ext_prefix");
        tick(1, 8'h5A, 0, "ext_commit");
        tick(0, 8'h00, 0, "after_commit");
        tick(1, 8'h5A, 0, "enter_esc");
        tick(1, 8'h76, 0, "esc_abort");
        tick(1, 8'h5A, 0, "enter_rst");
        tick(1, 8'h75, 1, "rst_over_key");
        tick(0, 8'h00, 0, "after_rst");
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 18))
                                              : int'($urandom_range(0, 2));
            for (int k = 0; k < gap; k++) tick(0, 8'h00, 0, "rand_gap");
            begin
                int idx;
                logic [7:0] c;
                idx = int'($urandom_range(0, 9));
                c = (idx == 9) ? 8'($urandom) : code_tbl[idx];
                tick(1, c, $urandom_range(0, 63) == 0, "rand_key");
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edit_field_sequencer.md
EDIT_FIELD_SEQUENCER -- requirements
Module: edit_field_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32'd500_000_000, idle cycles in edit mode before automatic abort.
REQ-002 Parameter TW, default 32, width of the timeout counter; TIMEOUT_CYC SHALL be less than 2^TW.
REQ-003 clk  in  1  system clock; all logic SHALL be rising-edge clocked.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 scan_code  in  8  PS/2 set-2 byte, valid only when got_data=1.
REQ-006 got_data  in  1  one-cycle strobe marking a new scan_code byte.
REQ-007 field_sel  out  2  active field: 0=none, 1=day, 2=month, 3=year; drives the en input of the field counters.
REQ-008 editing  out  1  high while in EDIT or BREAK state.
REQ-009 inc_pulse / dec_pulse  out  1 each  one-cycle step command for the field selected by field_sel.
REQ-010 commit_pulse / abort_pulse  out  1 each  one-cycle end-of-edit indication.

Function
REQ-011 States: IDLE, EDIT, BREAK, EXT; all outputs SHALL be registered.
REQ-012 Byte 0xF0 SHALL move the block to BREAK; the next got_data byte SHALL be discarded, and the block SHALL then return to EDIT, or to IDLE if it entered from IDLE.
REQ-013 Byte 0xE0 SHALL be consumed with no action, and the following byte SHALL be decoded normally (EXT state).
REQ-014 In IDLE, make code 0x5A (Enter) SHALL go to EDIT and set field_sel=1; all other make codes SHALL be ignored.
REQ-015 In EDIT, 0x75 SHALL cause inc_pulse and 0x72 SHALL cause dec_pulse, each high for exactly one cycle.
REQ-016 In EDIT, 0x74 SHALL advance field_sel 1→2→3→1, and 0x6B SHALL retreat it 3→2→1→3.
REQ-017 In EDIT, 0x5A SHALL cause commit_pulse, and 0x76 SHALL cause abort_pulse; both SHALL return the block to IDLE with field_sel=0.
REQ-018 Latency: any output response SHALL appear on the cycle after the got_data edge, and field_sel SHALL update on that same cycle.
REQ-019 A pulse SHALL never coincide with a field_sel change; inc_pulse or dec_pulse SHALL apply to the field_sel value of that cycle.
REQ-020 Typematic repeat (the same make code with no break in between) SHALL produce one pulse per byte.
REQ-021 Unmapped codes in EDIT SHALL produce no action, but SHALL reload the timeout.
REQ-022 The timeout counter SHALL reload to 0 on every got_data in EDIT/BREAK/EXT and SHALL saturate rather than wrap.
REQ-023 When the counter reaches TIMEOUT_CYC-1 with no got_data, the block SHALL assert abort_pulse and enter IDLE.
REQ-024 If got_data and timeout expiry occur in the same cycle, the key SHALL win and the timer SHALL reload.
REQ-025 got_data during IDLE SHALL NOT run the timer.

Reset
REQ-026 On rst: state=IDLE, field_sel=0, editing=0, all pulses=0, timeout counter=0.
REQ-027 Reset asserted mid-edit or mid-break SHALL override any got_data in the same cycle, and no pulse SHALL be emitted.

Structure
REQ-028 A shared package SHALL hold the key-code constants (0xF0, 0xE0, 0x5A, 0x76, 0x75, 0x72, 0x74, 0x6B), the state encoding and the field_sel encoding.
REQ-029 Prefix stripping (F0/E0 handling) SHALL be a sub-module, ps2_make_filter, that outputs make_valid/make_code to the sequencer FSM.

Verification
REQ-030 rst, then got_data 0x5A → next cycle editing=1, field_sel=1, no pulses.
REQ-031 In EDIT at field 1, send 0x75, then 0xF0, 0x75 → exactly one inc_pulse with field_sel=1; the break pair produces nothing.
REQ-032 From field 1, send 0x6B → field_sel=3; send 0x74 twice → field_sel=2; send 0x72 → one dec_pulse with field_sel=2.
REQ-033 TIMEOUT_CYC=16: enter EDIT, idle 15 cycles → abort_pulse, field_sel=0; repeat with got_data at cycle 15 → no abort, timer restarted.
REQ-034 In EDIT, send 0xE0, 0x5A → commit_pulse one cycle after the 0x5A strobe, then IDLE.
REQ-035 Assert rst on the same cycle as got_data 0x75 during EDIT → no inc_pulse, all outputs at reset values next cycle.
